peridot_host_uart_tx: RTL

//   Host-link UART transmitter that drives the board TXD pin; the counterpart of the RXD receiver path.

---
 rtl/peridot_host_uart_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/peridot_host_uart_tx.sv
// ---------------------------------------------------------------------------
// peridot_host_uart_tx
//   Host-link UART transmitter. Bytes arrive on a valid/ready sink, wait in
//   a small FIFO and are serialised onto TXD as start bit, 8 data bits (LSB
//   first) and STOPBITS stop bits at a fixed baud rate.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   in_valid    in   sink: in_data holds a byte to send
//   in_data     in   sink: byte to send
//   in_ready    out  sink: FIFO can take a byte this cycle
//   fifo_level  out  bytes currently buffered (0..2**FIFO_DEPTH_LOG2)
//   busy        out  frame in flight or bytes buffered
//   txd         out  serial line, idle high, driven straight from a flop
// ---------------------------------------------------------------------------
module peridot_host_uart_tx #(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int BAUDRATE        = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int STOPBITS        = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       busy,
  output logic                       txd
);

  localparam int DIV   = (CLOCK_FREQ + BAUDRATE / 2) / BAUDRATE;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("peridot_host_uart_tx: bit period DIV must be at least 2 clocks");
    end
    if (STOPBITS < 1 || STOPBITS > 2) begin : g_bad_stop
      $error("peridot_host_uart_tx: STOPBITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;
  logic                       push, pop;

  // Ready comes only from the registered level, so a pop in the same cycle
  // never opens the door for a push while full.
  assign in_ready   = (level_q != (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
  assign push       = in_valid & in_ready;
  assign fifo_level = level_q;

  // NOTE: the storage array has no reset; the pointers and level alone
  // decide which entries are meaningful, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // -------------------------------------------------------------------------
  // Serialiser
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // clocks within the current bit
  logic [2:0]       bit_q, bit_d;     // data bit index, reused for stop bits
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_W'(DIV - 1));

  // txd_d is decoded from the current state and registered, so the line lags
  // the state by one clock: a pop at edge N+1 shows as a falling txd at N+2.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'(STOPBITS - 1)) begin
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != IDLE) | (level_q != '0);

endmodule
